// File: rtl/mul_m_stage.sv
// ---------------------------------------------------------------------------
// mul_m_stage
//   Middle stage of the three-stage pipelined RV32M multiplier. Takes the
//   E-stage partial product, which covers multiplier bits [ITER_LO-1:0]. Adds
//   the shifted multiplicand terms for multiplier bits [ITER_HI:ITER_LO].
//   Registers everything the writeback stage needs.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   e_valid         incoming entry valid
//   e_rs1, e_rs2    raw operands (A = multiplier source, B = multiplicand)
//   e_mul_op        00=MUL 01=MULH 10=MULHSU 11=MULHU
//   e_product       partial product from the E stage
//   e_tag           destination register index
//   stall           hold this stage
//   flush           kill this stage's entry (takes priority over stall)
//   e_ready         ~stall
//   m_*             registered stage outputs
// ---------------------------------------------------------------------------
module mul_m_stage #(
    parameter int XLEN    = 32,
    parameter int ITER_LO = 11,
    parameter int ITER_HI = 21,
    parameter int TAG_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                e_valid,
    input  logic [XLEN-1:0]     e_rs1,
    input  logic [XLEN-1:0]     e_rs2,
    input  logic [1:0]          e_mul_op,
    input  logic [2*XLEN-1:0]   e_product,
    input  logic [TAG_W-1:0]    e_tag,
    input  logic                stall,
    input  logic                flush,
    output logic                e_ready,
    output logic                m_valid,
    output logic [XLEN-1:0]     m_rs1,
    output logic [XLEN-1:0]     m_rs2,
    output logic                m_negate,
    output logic [1:0]          m_mul_op,
    output logic [2*XLEN-1:0]   m_product,
    output logic [TAG_W-1:0]    m_tag
);

    localparam int NTERMS = ITER_HI - ITER_LO + 1;
    localparam int PW     = 2 * XLEN;

    // Absolute value of an operand when it is treated as signed.
    // The most negative value maps to itself, which is the correct
    // unsigned magnitude.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                  input logic            neg);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

    logic                sign_a;
    logic                sign_b;
    logic                neg_a;
    logic                neg_b;
    logic [NTERMS-1:0]   mag_a_win;
    logic [XLEN-1:0]     mag_b;
    logic                negate_next;
    logic [PW-1:0]       term [NTERMS];
    logic [PW-1:0]       product_next;

    assign sign_a = (e_mul_op != 2'b11);
    assign sign_b = ~e_mul_op[1];
    assign neg_a  = sign_a & e_rs1[XLEN-1];
    assign neg_b  = sign_b & e_rs2[XLEN-1];

    // Only the multiplier bits that this stage owns are kept.
    // Shifting then truncating avoids a full-width intermediate with dead bits.
    assign mag_a_win   = NTERMS'(magnitude(e_rs1, neg_a) >> ITER_LO);
    assign mag_b       = magnitude(e_rs2, neg_b);
    assign negate_next = neg_a ^ neg_b;

    // One shifted copy of the multiplicand per multiplier bit in the window.
    genvar gi;
    generate
        for (gi = 0; gi < NTERMS; gi++) begin : g_term
            assign term[gi] = mag_a_win[gi]
                            ? ({{XLEN{1'b0}}, mag_b} << (ITER_LO + gi))
                            : '0;
        end
    endgenerate

    // The sum wraps modulo 2^(2*XLEN).
    always_comb begin
        product_next = e_product;
        for (int i = 0; i < NTERMS; i++) begin
            product_next = product_next + term[i];
        end
    end

    assign e_ready = ~stall;

    logic              valid_reg;
    logic [XLEN-1:0]   rs1_reg;
    logic [XLEN-1:0]   rs2_reg;
    logic              negate_reg;
    logic [1:0]        mul_op_reg;
    logic [PW-1:0]     product_reg;
    logic [TAG_W-1:0]  tag_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg   <= 1'b0;
            rs1_reg     <= '0;
            rs2_reg     <= '0;
            negate_reg  <= 1'b0;
            mul_op_reg  <= '0;
            product_reg <= '0;
            tag_reg     <= '0;
        end else if (flush) begin
            // The data registers hold. Only the valid bit matters downstream.
            valid_reg   <= 1'b0;
        end else if (!stall) begin
            // Bubbles also load data. Consumers must qualify on m_valid.
            valid_reg   <= e_valid;
            rs1_reg     <= e_rs1;
            rs2_reg     <= e_rs2;
            negate_reg  <= negate_next;
            mul_op_reg  <= e_mul_op;
            product_reg <= product_next;
            tag_reg     <= e_tag;
        end
    end

    assign m_valid   = valid_reg;
    assign m_rs1     = rs1_reg;
    assign m_rs2     = rs2_reg;
    assign m_negate  = negate_reg;
    assign m_mul_op  = mul_op_reg;
    assign m_product = product_reg;
    assign m_tag     = tag_reg;

endmodule

// File: tb/tb_mul_m_stage.sv
// ---------------------------------------------------------------------------
// tb_mul_m_stage
//   Self-checking bench for mul_m_stage. It covers three kinds of stimulus.
//   - A table of directed vectors with hand-derived expected values.
//   - Hand-written stall, flush and reset sequences.
//   - Randomized back-to-back traffic checked against an arithmetic model.
// ---------------------------------------------------------------------------
module tb_mul_m_stage;

    localparam int XLEN    = 32;
    localparam int ITER_LO = 11;
    localparam int ITER_HI = 21;
    localparam int TAG_W   = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                e_valid;
    logic [XLEN-1:0]     e_rs1;
    logic [XLEN-1:0]     e_rs2;
    logic [1:0]          e_mul_op;
    logic [2*XLEN-1:0]   e_product;
    logic [TAG_W-1:0]    e_tag;
    logic                stall;
    logic                flush;
    logic                e_ready;
    logic                m_valid;
    logic [XLEN-1:0]     m_rs1;
    logic [XLEN-1:0]     m_rs2;
    logic                m_negate;
    logic [1:0]          m_mul_op;
    logic [2*XLEN-1:0]   m_product;
    logic [TAG_W-1:0]    m_tag;

    mul_m_stage #(
        .XLEN(XLEN), .ITER_LO(ITER_LO), .ITER_HI(ITER_HI), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst(rst), .e_valid(e_valid), .e_rs1(e_rs1), .e_rs2(e_rs2),
        .e_mul_op(e_mul_op), .e_product(e_product), .e_tag(e_tag),
        .stall(stall), .flush(flush), .e_ready(e_ready), .m_valid(m_valid),
        .m_rs1(m_rs1), .m_rs2(m_rs2), .m_negate(m_negate), .m_mul_op(m_mul_op),
        .m_product(m_product), .m_tag(m_tag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model. It uses the signed/unsigned magnitudes of the operands.
    // It keeps the multiplier bits in the window and multiplies them in plain
    // 64-bit arithmetic.
    function automatic logic [63:0] ref_product(input logic [31:0] rs1, input logic [31:0] rs2,
                                                input logic [1:0] op, input logic [63:0] ep);
        logic        sa, sb;
        logic [31:0] ma, mb;
        logic [63:0] window;
        sa = (op != 2'b11);
        sb = (op == 2'b00) || (op == 2'b01);
        ma = (sa && rs1[31]) ? 32'(32'd0 - rs1) : rs1;
        mb = (sb && rs2[31]) ? 32'(32'd0 - rs2) : rs2;
        window = ((64'(ma) >> ITER_LO) % (64'd1 << (ITER_HI - ITER_LO + 1))) << ITER_LO;
        return ep + 64'(mb) * window;
    endfunction

    function automatic logic ref_negate(input logic [31:0] rs1, input logic [31:0] rs2,
                                        input logic [1:0] op);
        logic a_neg, b_neg;
        a_neg = (op != 2'b11) && rs1[31];
        b_neg = (op == 2'b00 || op == 2'b01) && rs2[31];
        return a_neg != b_neg;
    endfunction

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [63:0] ep, input logic [4:0] tag);
        e_valid = v; e_rs1 = a; e_rs2 = b; e_mul_op = op; e_product = ep; e_tag = tag;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [1:0]  op;
        logic [63:0] ep;
        logic [4:0]  tag;
        logic [63:0] exp_product;
        logic        exp_negate;
    } vec_t;

    vec_t vecs [9];

    logic [31:0] ra, rb;
    logic [1:0]  rop;
    logic [63:0] rep;
    logic [4:0]  rtag;

    initial begin
        // Directed vectors. Expected values are derived by hand.
        vecs[0] = '{32'h0020_0000, 32'h3,          2'b11, 64'h0,  5'd1, 64'h0000_0000_0060_0000, 1'b0};
        vecs[1] = '{32'hFFFF_F800, 32'h5,          2'b01, 64'h7,  5'd2, 64'h0000_0000_0000_2807, 1'b1};
        vecs[2] = '{32'hFFFF_F800, 32'hFFFF_FFFB,  2'b01, 64'h7,  5'd3, 64'h0000_0000_0000_2807, 1'b0};
        vecs[3] = '{32'hFFFF_FFFF, 32'h8000_0000,  2'b10, 64'h1234_5678_9ABC_DEF0, 5'd4,
                    64'h1234_5678_9ABC_DEF0, 1'b1};
        vecs[4] = '{32'hFFFF_FFFF, 32'h8000_0000,  2'b11, 64'h1234_5678_9ABC_DEF0, 5'd5,
                    64'h1234_5678_9ABC_DEF0 + 64'h0000_0000_8000_0000 * 64'h0000_0000_003F_F800, 1'b0};
        // Most negative operand on both sides. Its magnitude is 0x80000000,
        // which has no bits in the window.
        vecs[5] = '{32'h8000_0000, 32'h8000_0000,  2'b01, 64'h55, 5'd6, 64'h55, 1'b0};
        // Every window bit set, with an all-ones unsigned multiplicand.
        vecs[6] = '{32'h003F_F800, 32'hFFFF_FFFF,  2'b11, 64'h0,  5'd7, 64'h003F_F7FF_FFC0_0800, 1'b0};
        // Bits outside the window only, so the product passes through unchanged.
        vecs[7] = '{32'hFFC0_07FF, 32'h1234_5678,  2'b11, 64'hABCD, 5'd8, 64'hABCD, 1'b0};
        // The sum wraps modulo 2^64.
        vecs[8] = '{32'h0000_0800, 32'h1,          2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 64'h7FF, 1'b0};

        // ---------------- reset ----------------
        stall = 1'b1; flush = 1'b1; rst = 1'b1;
        drive(1'b1, $urandom, $urandom, 2'($urandom), {$urandom, $urandom}, 5'($urandom));
        tick();
        drive(1'b1, $urandom, $urandom, 2'($urandom), {$urandom, $urandom}, 5'($urandom));
        tick();
        chk("rst_valid",   64'(m_valid),   64'd0);
        chk("rst_rs1",     64'(m_rs1),     64'd0);
        chk("rst_rs2",     64'(m_rs2),     64'd0);
        chk("rst_negate",  64'(m_negate),  64'd0);
        chk("rst_op",      64'(m_mul_op),  64'd0);
        chk("rst_product", m_product,      64'd0);
        chk("rst_tag",     64'(m_tag),     64'd0);
        $display("txn reset: m_valid=%0d m_product=0x%0h", m_valid, m_product);
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b0, $urandom, $urandom, 2'($urandom), {$urandom, $urandom}, 5'($urandom));
        tick();
        chk("bubble_valid", 64'(m_valid), 64'd0);
        chk("ready_idle",   64'(e_ready), 64'd1);

        // ---------------- directed table ----------------
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, vecs[i].rs1, vecs[i].rs2, vecs[i].op, vecs[i].ep, vecs[i].tag);
            tick();
            $display("txn vec%0d: rs1=0x%08h rs2=0x%08h op=%0d -> product=0x%016h negate=%0d",
                     i, vecs[i].rs1, vecs[i].rs2, vecs[i].op, m_product, m_negate);
            chk($sformatf("vec%0d_product", i), m_product, vecs[i].exp_product);
            chk($sformatf("vec%0d_negate", i), 64'(m_negate), 64'(vecs[i].exp_negate));
            chk($sformatf("vec%0d_valid", i), 64'(m_valid), 64'd1);
            chk($sformatf("vec%0d_rs1", i), 64'(m_rs1), 64'(vecs[i].rs1));
            chk($sformatf("vec%0d_rs2", i), 64'(m_rs2), 64'(vecs[i].rs2));
            chk($sformatf("vec%0d_op", i), 64'(m_mul_op), 64'(vecs[i].op));
            chk($sformatf("vec%0d_tag", i), 64'(m_tag), 64'(vecs[i].tag));
        end

        // ---------------- stall / flush ----------------
        drive(1'b1, 32'hFFFF_F800, 32'h5, 2'b01, 64'h7, 5'd11);            // entry A
        tick();
        chk("stallA_load", m_product, 64'h2807);
        stall = 1'b1;
        drive(1'b1, 32'h0020_0000, 32'h3, 2'b11, 64'h0, 5'd12);             // entry B
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d_ready", c), 64'(e_ready), 64'd0);
            tick();
            $display("txn stall%0d: m_tag=%0d m_product=0x%0h", c, m_tag, m_product);
            chk($sformatf("stall%0d_product", c), m_product, 64'h2807);
            chk($sformatf("stall%0d_tag", c), 64'(m_tag), 64'd11);
            chk($sformatf("stall%0d_valid", c), 64'(m_valid), 64'd1);
            chk($sformatf("stall%0d_rs1", c), 64'(m_rs1), 64'hFFFF_F800);
        end
        stall = 1'b0;
        #1;
        chk("unstall_ready", 64'(e_ready), 64'd1);
        tick();
        $display("txn unstall: m_tag=%0d m_product=0x%0h", m_tag, m_product);
        chk("unstallB_product", m_product, 64'h0060_0000);
        chk("unstallB_tag", 64'(m_tag), 64'd12);
        chk("unstallB_valid", 64'(m_valid), 64'd1);
        stall = 1'b1; flush = 1'b1;
        tick();
        $display("txn stall+flush: m_valid=%0d", m_valid);
        chk("stallflush_valid", 64'(m_valid), 64'd0);
        stall = 1'b0; flush = 1'b0;
        tick();
        chk("reload_valid", 64'(m_valid), 64'd1);
        flush = 1'b1;
        tick();
        chk("flush_valid", 64'(m_valid), 64'd0);
        flush = 1'b0;

        // ---------------- back-to-back random ----------------
        for (int k = 0; k < 8; k++) begin
            ra = $urandom; rb = $urandom; rop = 2'($urandom_range(0, 3));
            rep = {$urandom, $urandom}; rtag = 5'(k + 16);
            drive(1'b1, ra, rb, rop, rep, rtag);
            tick();
            $display("txn b2b%0d: rs1=0x%08h rs2=0x%08h op=%0d -> product=0x%016h tag=%0d",
                     k, ra, rb, rop, m_product, m_tag);
            chk($sformatf("b2b%0d_product", k), m_product, ref_product(ra, rb, rop, rep));
            chk($sformatf("b2b%0d_negate", k), 64'(m_negate), 64'(ref_negate(ra, rb, rop)));
            chk($sformatf("b2b%0d_tag", k), 64'(m_tag), 64'(rtag));
            chk($sformatf("b2b%0d_valid", k), 64'(m_valid), 64'd1);
        end

        // Reset while stalled and flushing clears the in-flight entry.
        stall = 1'b1; flush = 1'b1; rst = 1'b1;
        tick();
        chk("rst2_product", m_product, 64'd0);
        chk("rst2_tag", 64'(m_tag), 64'd0);
        chk("rst2_valid", 64'(m_valid), 64'd0);
        rst = 1'b0; stall = 1'b0; flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
